demux_1to8: RTL and testbench
=============================

Name: demux_1to8

Overview:
- Registered 1-to-8 demultiplexer with enable: routes a single data input to one of eight output lanes selected by a 3-bit select.
- All non-selected lanes are driven to zero.
- Used as a lane-steering/fan-out element in datapaths. Output is registered, so downstream logic sees a clean one-cycle-latency copy.

Parameters:
- DATA_W, 1, width of the data input and of each output lane.
- N_OUT, 8, number of output lanes. Fixed at 8; SEL_W = 3 is derived from it.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- e  input  1  enable; 1 = route data, 0 = all lanes zero.
- in  input  DATA_W  data to be routed.
- sel  input  3  lane select, 0..7.
- out  output  N_OUT*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- sel_onehot  output  N_OUT  registered one-hot of the active lane; all zero when disabled.

Behaviour:
- Reset
  - rst_n = 0 at a rising edge sets out = 0 and sel_onehot = 0 on that edge.
  - Reset overrides e, in and sel.
  - Reset is synchronous: asserting rst_n between edges has no effect until the next edge.
- Normal edge (rst_n = 1)
  - If e = 1: lane sel of out takes in; every other lane takes 0; sel_onehot takes (1 << sel).
  - If e = 0: out = 0 and sel_onehot = 0.
- Latency: exactly 1 cycle from sampled {e, in, sel} to out / sel_onehot. No combinational path from inputs to outputs.
- Every edge re-evaluates fully; no lane holds stale data after sel changes.
  - Example: sel 3 -> 5 with e = 1 gives lane 3 = 0 and lane 5 = in after the next edge.
- sel is a full 3-bit range with no illegal codes. Stimulus incrementing sel wraps 7 -> 0 naturally, and lane 0 is selected after the wrap.
- Toggling in every cycle with fixed sel produces a toggling selected lane, delayed by 1 cycle. Other lanes stay 0.
- Simultaneous e fall and sel change: disable wins, so out = 0 on that edge.
- Reset release: the first edge with rst_n = 1 computes outputs from the inputs on that edge.
- With X/Z on inputs, behaviour is undefined. The bench drives only known values.

Decomposition:
- Shared package demux_pkg:
  - constants N_OUT = 8 and SEL_W = 3;
  - typedef sel_t (logic [SEL_W-1:0]);
  - typedef onehot_t (logic [N_OUT-1:0]).
- Sub-module decoder_3to8 (combinational):
  - inputs: sel, en;
  - output: onehot = en ? (1 << sel) : 0.
- Top level:
  - gates in into each lane with the matching onehot bit (replicated to DATA_W);
  - registers both the lanes and the onehot under rst_n.

Test Plan:
- Reset: hold rst_n = 0 with e = 1, sel = 2, in = 1 for 3 edges -> out = 8'h00 and sel_onehot = 8'h00 after each edge. Release; the next edge gives out = 8'h04.
- Disabled: rst_n = 1, e = 0, in = 1, sweep sel 0..7 -> out = 8'h00 and sel_onehot = 8'h00 every cycle.
- Enabled sweep: e = 1, in = 1, sel = 0..7 one per cycle -> out = 8'h01, 02, 04, 08, 10, 20, 40, 80 each one cycle later. Then sel wraps to 0 -> out = 8'h01.
- Toggle data: e = 1, sel = 6, in alternating 1/0 every cycle -> out alternates 8'h40 / 8'h00, delayed by 1 cycle. sel_onehot = 8'h40 constant.
- Mid-operation: e = 1, sel = 5, in = 1 gives out = 8'h20. Then:
  - drop e -> next edge out = 8'h00;
  - re-enable, then assert rst_n = 0 for one edge -> out = 8'h00;
  - release with sel = 1, in = 1 -> out = 8'h02.
- DATA_W = 4 instance: e = 1, sel = 3, in = 4'hA -> out = 32'h0000_A000, with all other lanes 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared lane-select types and sizing for the 1-to-8 demux.
// Lane count is fixed at 8, so the select width is fixed at 3 bits.
package demux_pkg;

  localparam int N_OUT = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_OUT-1:0] onehot_t;

  // Bit 'sel' set when enabled, all zero otherwise.
  function automatic onehot_t onehot_of(input sel_t sel, input logic en);
    onehot_t oh;
    oh = '0;
    if (en) begin
      oh = onehot_t'(1) << sel;
    end
    return oh;
  endfunction

endpackage

// File: rtl/demux_1to8_if.sv
// Data/select bundle for the demux: the master drives e/in/sel,
// the slave (the demux) returns the registered lanes and one-hot.
interface demux_1to8_if
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
);

  logic                    e;
  logic [DATA_W-1:0]       in;
  sel_t                    sel;
  logic [N_OUT*DATA_W-1:0] out;
  onehot_t                 sel_onehot;

  modport master (
    output e,
    output in,
    output sel,
    input  out,
    input  sel_onehot
  );

  modport slave (
    input  e,
    input  in,
    input  sel,
    output out,
    output sel_onehot
  );

endinterface

// File: rtl/decoder_3to8.sv
// Combinational 3-to-8 decoder with enable; zero latency.
// No backpressure: pure function of the current select and enable.
module decoder_3to8
  import demux_pkg::*;
(
  input  sel_t    sel,
  input  logic    en,
  output onehot_t onehot
);

  assign onehot = onehot_of(sel, en);

endmodule

// File: rtl/demux_1to8.sv
// Registered 1-to-8 lane demux; inputs to lanes/one-hot in exactly 1 cycle.
// No backpressure: new inputs are sampled on every rising edge.
module demux_1to8
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_1to8_if.slave   bus
);

  onehot_t                 onehot_d;
  onehot_t                 onehot_q;
  logic [N_OUT*DATA_W-1:0] out_d;
  logic [N_OUT*DATA_W-1:0] out_q;

  decoder_3to8 u_dec (
    .sel    (bus.sel),
    .en     (bus.e),
    .onehot (onehot_d)
  );

  // Every lane is recomputed each cycle, so a deselected lane drops to zero.
  always_comb begin
    out_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_d[k*DATA_W +: DATA_W] = bus.in & {DATA_W{onehot_d[k]}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      onehot_q <= '0;
    end else begin
      out_q    <= out_d;
      onehot_q <= onehot_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.sel_onehot = onehot_q;

endmodule

// File: tb/tb_demux_1to8.sv
// Directed-vector bench for demux_1to8 at DATA_W = 1 and DATA_W = 4.
module tb_demux_1to8;
  import demux_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  localparam logic [7:0] SWEEP_EXP [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                           8'h10, 8'h20, 8'h40, 8'h80};

  demux_1to8_if #(.DATA_W(1)) bus1 ();
  demux_1to8_if #(.DATA_W(4)) bus4 ();

  demux_1to8 #(.DATA_W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  demux_1to8 #(.DATA_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held with active-looking inputs.
    rst_n    = 1'b0;
    bus1.e   = 1'b1;
    bus1.sel = 3'd2;
    bus1.in  = 1'b1;
    bus4.e   = 1'b0;
    bus4.sel = 3'd0;
    bus4.in  = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_out_%0d", i), 32'(bus1.out), 32'h00);
      chk($sformatf("rst_oh_%0d", i), 32'(bus1.sel_onehot), 32'h00);
    end
    rst_n = 1'b1;
    tick();
    chk("rel_out", 32'(bus1.out), 32'h04);
    chk("rel_oh", 32'(bus1.sel_onehot), 32'h04);

    // Disabled: nothing routed regardless of sel.
    bus1.e  = 1'b0;
    bus1.in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus1.sel = sel_t'(i);
      tick();
      chk($sformatf("dis_out_%0d", i), 32'(bus1.out), 32'h00);
      chk($sformatf("dis_oh_%0d", i), 32'(bus1.sel_onehot), 32'h00);
    end

    // Enabled sweep, then wrap 7 -> 0.
    bus1.e = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus1.sel = sel_t'(i);
      tick();
      chk($sformatf("sweep_out_%0d", i), 32'(bus1.out), 32'(SWEEP_EXP[i]));
      chk($sformatf("sweep_oh_%0d", i), 32'(bus1.sel_onehot), 32'(SWEEP_EXP[i]));
    end
    bus1.sel = bus1.sel + 3'd1;
    tick();
    chk("wrap_out", 32'(bus1.out), 32'h01);

    // Toggling data on lane 6.
    bus1.sel = 3'd6;
    for (int i = 0; i < 6; i++) begin
      bus1.in = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("tog_out_%0d", i), 32'(bus1.out), (i % 2 == 0) ? 32'h40 : 32'h00);
      chk($sformatf("tog_oh_%0d", i), 32'(bus1.sel_onehot), 32'h40);
    end

    // Lane change clears the old lane.
    bus1.in  = 1'b1;
    bus1.sel = 3'd3;
    tick();
    chk("sel3_out", 32'(bus1.out), 32'h08);
    bus1.sel = 3'd5;
    tick();
    chk("sel5_out", 32'(bus1.out), 32'h20);

    // Disable, re-enable, then a synchronous reset.
    bus1.e = 1'b0;
    tick();
    chk("drop_e_out", 32'(bus1.out), 32'h00);
    bus1.e = 1'b1;
    tick();
    chk("reen_out", 32'(bus1.out), 32'h20);
    rst_n = 1'b0;
    #2;
    chk("rst_midcycle_out", 32'(bus1.out), 32'h20);
    tick();
    chk("rst_edge_out", 32'(bus1.out), 32'h00);
    chk("rst_edge_oh", 32'(bus1.sel_onehot), 32'h00);
    rst_n    = 1'b1;
    bus1.sel = 3'd1;
    bus1.in  = 1'b1;
    tick();
    chk("post_rst_out", 32'(bus1.out), 32'h02);

    // Disable and sel change on the same edge: disable wins.
    bus1.e   = 1'b0;
    bus1.sel = 3'd7;
    tick();
    chk("dis_wins_out", 32'(bus1.out), 32'h00);
    chk("dis_wins_oh", 32'(bus1.sel_onehot), 32'h00);

    // Wide lanes.
    bus4.e   = 1'b1;
    bus4.sel = 3'd3;
    bus4.in  = 4'hA;
    tick();
    chk("w4_out", bus4.out, 32'h0000_A000);
    chk("w4_oh", 32'(bus4.sel_onehot), 32'h08);
    bus4.sel = 3'd7;
    bus4.in  = 4'h5;
    tick();
    chk("w4_top_out", bus4.out, 32'h5000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
